// File: rtl/debug_tx_sequencer_pkg.sv
// Shared debug definitions: sequencer state encoding, frame sync byte and
// the command characters echoed back as acknowledge bytes.
package debug_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK      = 3'd1,
    HEADER   = 3'd2,
    LEN      = 3'd3,
    PAYLOAD  = 3'd4,
    CHECKSUM = 3'd5,
    DONE     = 3'd6
  } seqState_e;

  localparam logic [7:0] DBG_HEADER_BYTE = 8'hA5;

  localparam logic [7:0] CMD_CAPTURE = 8'd99;   // 'c'
  localparam logic [7:0] CMD_STEP    = 8'd115;  // 's'
  localparam logic [7:0] CMD_NEXT    = 8'd110;  // 'n'

endpackage

// File: rtl/debug_tx_sequencer.sv
// Owns the UART TX FIFO write port: emits atomic snapshot frames
// (header, length, payload, checksum) and single-byte command acks.
module debug_tx_sequencer
  import debug_tx_sequencer_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 55,
  parameter int         IDX_W         = 6,
  parameter logic [7:0] HEADER_BYTE   = DBG_HEADER_BYTE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frameStart,
  output logic [IDX_W-1:0] frameByteIndex,
  input  logic [7:0]       frameByteData,
  input  logic             ackReq,
  input  logic [7:0]       ackByte,
  output logic             ackGrant,
  input  logic             txFifoFull,
  output logic             txFifoWrite,
  output logic [7:0]       txFifoData,
  output logic             frameBusy,
  output logic             frameDone
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_BYTES);

  seqState_e        state;
  logic [IDX_W-1:0] index;
  logic [7:0]       checksum;
  logic             pendingFrame;
  logic             emitting;

  assign emitting       = (state == ACK) || (state == HEADER) || (state == LEN) ||
                          (state == PAYLOAD) || (state == CHECKSUM);
  assign txFifoWrite    = emitting && !txFifoFull;
  assign ackGrant       = (state == ACK) && !txFifoFull;
  assign frameBusy      = (state == HEADER) || (state == LEN) || (state == PAYLOAD) ||
                          (state == CHECKSUM) || (state == DONE);
  assign frameDone      = (state == DONE);
  assign frameByteIndex = (state == PAYLOAD) ? index : '0;

  always_comb begin
    txFifoData = 8'h00;
    case (state)
      ACK:      txFifoData = ackByte;
      HEADER:   txFifoData = HEADER_BYTE;
      LEN:      txFifoData = LEN_BYTE;
      PAYLOAD:  txFifoData = frameByteData;
      CHECKSUM: txFifoData = checksum;
      default:  txFifoData = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      index        <= '0;
      checksum     <= 8'h00;
      pendingFrame <= 1'b0;
    end else begin
      // Requests during a frame merge into it rather than queueing another.
      if (frameStart && !frameBusy) pendingFrame <= 1'b1;
      case (state)
        IDLE: begin
          if (ackReq) state <= ACK;
          else if (pendingFrame || frameStart) begin
            state        <= HEADER;
            pendingFrame <= 1'b0;
          end
        end
        ACK:      if (txFifoWrite) state <= IDLE;
        HEADER: begin
          if (txFifoWrite) begin
            state    <= LEN;
            checksum <= 8'h00;
          end
        end
        LEN: begin
          if (txFifoWrite) begin
            state <= PAYLOAD;
            index <= '0;
          end
        end
        PAYLOAD: begin
          if (txFifoWrite) begin
            checksum <= checksum + frameByteData;
            if (index == LAST_IDX) begin
              state <= CHECKSUM;
              index <= '0;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        CHECKSUM: if (txFifoWrite) state <= DONE;
        // A held-off ack goes out in the cycle right after DONE.
        DONE:     state <= ackReq ? ACK : IDLE;
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Scoreboard bench for debug_tx_sequencer with a 4-byte payload.
module tb_debug_tx_sequencer;
  import debug_tx_sequencer_pkg::*;

  localparam int PB = 4;
  localparam int IW = 2;

  logic          clock, reset;
  logic          frameStart, ackReq, ackGrant, txFifoFull, txFifoWrite;
  logic          frameBusy, frameDone;
  logic [IW-1:0] frameByteIndex;
  logic [7:0]    frameByteData, ackByte, txFifoData;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         isAck;
  } expWr_t;

  expWr_t sb[$];
  int     cyc = 0;
  int     nChecks = 0, nFail = 0;
  int     stallFrom = 0, stallTo = 0;
  int     expDone = -1, busyFrom = -1;
  bit     doneOn = 0, ffMode = 0;

  debug_tx_sequencer #(.PAYLOAD_BYTES(PB), .IDX_W(IW)) dut (
    .clock(clock), .reset(reset), .frameStart(frameStart),
    .frameByteIndex(frameByteIndex), .frameByteData(frameByteData),
    .ackReq(ackReq), .ackByte(ackByte), .ackGrant(ackGrant),
    .txFifoFull(txFifoFull), .txFifoWrite(txFifoWrite), .txFifoData(txFifoData),
    .frameBusy(frameBusy), .frameDone(frameDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign txFifoFull    = (cyc >= stallFrom) && (cyc < stallTo);
  assign frameByteData = ffMode ? 8'hFF : 8'(frameByteIndex) + 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int nextFree(input int c);
    int n = c;
    while (n >= stallFrom && n < stallTo) n++;
    return n;
  endfunction

  // Predicts every write of a frame whose HEADER state begins at hdrCyc.
  task automatic expectFrame(input int hdrCyc);
    int         c;
    logic [7:0] sum, b;
    c = nextFree(hdrCyc);
    sb.push_back('{c, DBG_HEADER_BYTE, 1'b0});
    c = nextFree(c + 1);
    sb.push_back('{c, 8'(PB), 1'b0});
    sum = 8'h00;
    for (int i = 0; i < PB; i++) begin
      b   = ffMode ? 8'hFF : 8'(i + 1);
      sum = sum + b;
      c   = nextFree(c + 1);
      sb.push_back('{c, b, 1'b0});
    end
    c = nextFree(c + 1);
    sb.push_back('{c, sum, 1'b0});
    expDone  = c + 1;
    busyFrom = hdrCyc;
    doneOn   = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (txFifoWrite) begin
        if (sb.size() == 0) chk("unexpectedWrite", {24'd0, txFifoData}, 32'hFFFF_FFFF);
        else begin
          expWr_t e;
          e = sb.pop_front();
          chk("wrCycle", cyc, e.cyc);
          chk("wrData", {24'd0, txFifoData}, {24'd0, e.data});
          chk("ackGrant", {31'd0, ackGrant}, {31'd0, e.isAck});
        end
      end
      if (ackGrant) begin
        chk("grantWithWrite", {31'd0, txFifoWrite}, 32'd1);
        ackReq = 1'b0;
      end
      if (doneOn) begin
        chk("frameDone", {31'd0, frameDone}, {31'd0, cyc == expDone});
        chk("frameBusy", {31'd0, frameBusy}, {31'd0, (cyc >= busyFrom) && (cyc <= expDone)});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && cyc > expDone + 1) break;
      tick();
    end
    chk("drainPending", sb.size(), 0);
    tick();
  endtask

  task automatic startFrame(output int t0);
    tick();
    t0 = cyc;
    frameStart = 1'b1;
  endtask

  initial begin
    int t0;
    reset = 1'b0; frameStart = 1'b0; ackReq = 1'b0; ackByte = 8'h00;
    #2;
    chk("rstWrite", {31'd0, txFifoWrite}, 32'd0);
    chk("rstData", {24'd0, txFifoData}, 32'd0);
    chk("rstGrant", {31'd0, ackGrant}, 32'd0);
    chk("rstBusy", {31'd0, frameBusy}, 32'd0);
    chk("rstDone", {31'd0, frameDone}, 32'd0);
    chk("rstIndex", {30'd0, frameByteIndex}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Plain frame, FIFO never full
    startFrame(t0);
    expectFrame(t0 + 1);
    tick(); frameStart = 1'b0;
    drain();

    // Same frame with FIFO full on relative cycles 3..5
    stallFrom = cyc + 4; stallTo = cyc + 7;
    startFrame(t0);
    expectFrame(t0 + 1);
    tick(); frameStart = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("stallIndex", {30'd0, frameByteIndex}, 32'd0);
      chk("stallNoWrite", {31'd0, txFifoWrite}, 32'd0);
      tick();
    end
    drain();
    stallFrom = 0; stallTo = 0;

    // Ack and frame requested together: ack first, then the pending frame
    startFrame(t0);
    ackReq = 1'b1; ackByte = CMD_STEP;
    sb.push_back('{t0 + 1, CMD_STEP, 1'b1});
    expectFrame(t0 + 3);
    tick(); frameStart = 1'b0;
    drain();

    // Ack raised mid-payload is held off until after DONE
    startFrame(t0);
    expectFrame(t0 + 1);
    tick(); frameStart = 1'b0;
    tick(); tick(); tick();
    ackReq = 1'b1; ackByte = CMD_NEXT;
    sb.push_back('{expDone + 1, CMD_NEXT, 1'b1});
    drain();

    // All-0xFF payload wraps the checksum
    ffMode = 1'b1;
    startFrame(t0);
    expectFrame(t0 + 1);
    tick(); frameStart = 1'b0;
    drain();
    ffMode = 1'b0;

    // Reset in the middle of PAYLOAD truncates the frame
    startFrame(t0);
    expectFrame(t0 + 1);
    tick(); frameStart = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("midRstWrite", {31'd0, txFifoWrite}, 32'd0);
    chk("midRstData", {24'd0, txFifoData}, 32'd0);
    chk("midRstBusy", {31'd0, frameBusy}, 32'd0);
    chk("midRstIndex", {30'd0, frameByteIndex}, 32'd0);
    sb.delete();
    doneOn = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    startFrame(t0);
    expectFrame(t0 + 1);
    tick(); frameStart = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
